// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (imem) and load/store (dmem) requesters.
// Round-robin request grant; an in-order ID queue steers responses back to their issuer.
module mem_port_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       imemreq_val,
    output logic                       imemreq_rdy,
    input  logic [31:0]                imemreq_addr,
    output logic                       imemresp_val,
    input  logic                       imemresp_rdy,
    output logic [31:0]                imemresp_data,

    input  logic                       dmemreq_val,
    output logic                       dmemreq_rdy,
    input  logic                       dmemreq_type,
    input  logic [31:0]                dmemreq_addr,
    input  logic [31:0]                dmemreq_wdata,
    output logic                       dmemresp_val,
    input  logic                       dmemresp_rdy,
    output logic [31:0]                dmemresp_data,

    output logic                       memreq_val,
    input  logic                       memreq_rdy,
    output logic                       memreq_type,
    output logic [31:0]                memreq_addr,
    output logic [31:0]                memreq_wdata,
    input  logic                       memresp_val,
    output logic                       memresp_rdy,
    input  logic [31:0]                memresp_data,

    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Requester IDs held in the queue; prio uses the same encoding.
    localparam logic ID_IMEM = 1'b0;
    localparam logic ID_DMEM = 1'b1;

    logic [DEPTH-1:0] id_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic             prio_q;
    logic             err_q;

    logic full;
    logic empty;
    logic grant_dmem;
    logic both_val;
    logic can_issue;
    logic req_fire;
    logic resp_fire;
    logic head_id;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign both_val   = imemreq_val & dmemreq_val;
    assign grant_dmem = dmemreq_val & (~imemreq_val | (prio_q == ID_DMEM));

    // Outputs are forced low while reset is asserted, even with inputs active.
    assign can_issue   = rst & memreq_rdy & ~full;
    assign memreq_val  = rst & (imemreq_val | dmemreq_val) & ~full;
    assign dmemreq_rdy = can_issue & grant_dmem;
    assign imemreq_rdy = can_issue & imemreq_val & ~grant_dmem;
    assign req_fire    = memreq_val & memreq_rdy;

    always_comb begin
        memreq_type  = 1'b0;
        memreq_addr  = imemreq_addr;
        memreq_wdata = 32'h0;
        if (grant_dmem) begin
            memreq_type  = dmemreq_type;
            memreq_addr  = dmemreq_addr;
            memreq_wdata = dmemreq_wdata;
        end
    end

    assign head_id       = id_q[head_q];
    assign memresp_rdy   = rst & ~empty & ((head_id == ID_DMEM) ? dmemresp_rdy : imemresp_rdy);
    assign imemresp_val  = rst & ~empty & (head_id == ID_IMEM) & memresp_val;
    assign dmemresp_val  = rst & ~empty & (head_id == ID_DMEM) & memresp_val;
    assign imemresp_data = memresp_data;
    assign dmemresp_data = memresp_data;
    assign resp_fire     = memresp_val & memresp_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            prio_q  <= ID_DMEM;
            err_q   <= 1'b0;
        end else begin
            if (req_fire) begin
                id_q[tail_q] <= grant_dmem;
                tail_q       <= tail_q + PW'(1);
            end
            if (resp_fire) begin
                head_q <= head_q + PW'(1);
            end
            if (req_fire && !resp_fire) begin
                count_q <= count_q + CW'(1);
            end else if (!req_fire && resp_fire) begin
                count_q <= count_q - CW'(1);
            end
            // Priority rotates only when a contested request actually issues.
            if (req_fire && both_val) begin
                prio_q <= ~grant_dmem;
            end
            if (memresp_val && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign outstanding = count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (DEPTH=4): reset, grant rotation, full queue,
// response steering with back-pressure, and the empty-queue error flag.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic        imemresp_rdy;
    logic [31:0] imemresp_data;
    logic        dmemreq_val;
    logic        dmemreq_rdy;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic        dmemresp_val;
    logic        dmemresp_rdy;
    logic [31:0] dmemresp_data;
    logic        memreq_val;
    logic        memreq_rdy;
    logic        memreq_type;
    logic [31:0] memreq_addr;
    logic [31:0] memreq_wdata;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [31:0] memresp_data;
    logic [2:0]  outstanding;
    logic        err;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .imemreq_val   (imemreq_val),
        .imemreq_rdy   (imemreq_rdy),
        .imemreq_addr  (imemreq_addr),
        .imemresp_val  (imemresp_val),
        .imemresp_rdy  (imemresp_rdy),
        .imemresp_data (imemresp_data),
        .dmemreq_val   (dmemreq_val),
        .dmemreq_rdy   (dmemreq_rdy),
        .dmemreq_type  (dmemreq_type),
        .dmemreq_addr  (dmemreq_addr),
        .dmemreq_wdata (dmemreq_wdata),
        .dmemresp_val  (dmemresp_val),
        .dmemresp_rdy  (dmemresp_rdy),
        .dmemresp_data (dmemresp_data),
        .memreq_val    (memreq_val),
        .memreq_rdy    (memreq_rdy),
        .memreq_type   (memreq_type),
        .memreq_addr   (memreq_addr),
        .memreq_wdata  (memreq_wdata),
        .memresp_val   (memresp_val),
        .memresp_rdy   (memresp_rdy),
        .memresp_data  (memresp_data),
        .outstanding   (outstanding),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        // Reset with every input high: all handshake outputs must stay low.
        rst = 1'b0;
        imemreq_val = 1'b1; imemreq_addr = 32'hFFFF_FFFF; imemresp_rdy = 1'b1;
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'hFFFF_FFFF;
        dmemreq_wdata = 32'hFFFF_FFFF; dmemresp_rdy = 1'b1;
        memreq_rdy = 1'b1; memresp_val = 1'b1; memresp_data = 32'hFFFF_FFFF;
        settle();
        chk("rst_imemreq_rdy", 32'(imemreq_rdy), 32'd0);
        chk("rst_dmemreq_rdy", 32'(dmemreq_rdy), 32'd0);
        chk("rst_memreq_val", 32'(memreq_val), 32'd0);
        chk("rst_memresp_rdy", 32'(memresp_rdy), 32'd0);
        chk("rst_imemresp_val", 32'(imemresp_val), 32'd0);
        chk("rst_dmemresp_val", 32'(dmemresp_val), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        chk("rst_held_err", 32'(err), 32'd0);

        imemreq_val = 1'b0; dmemreq_val = 1'b0; memresp_val = 1'b0;
        dmemreq_type = 1'b0; dmemreq_wdata = 32'h0;
        tick();
        rst = 1'b1;
        tick();

        // imem-only request, then its response.
        imemreq_val = 1'b1; imemreq_addr = 32'h100;
        settle();
        chk("t2_memreq_val", 32'(memreq_val), 32'd1);
        chk("t2_memreq_addr", memreq_addr, 32'h100);
        chk("t2_memreq_type", 32'(memreq_type), 32'd0);
        chk("t2_imemreq_rdy", 32'(imemreq_rdy), 32'd1);
        chk("t2_dmemreq_rdy", 32'(dmemreq_rdy), 32'd0);
        tick();
        chk("t2_outstanding", 32'(outstanding), 32'd1);
        imemreq_val = 1'b0; memresp_val = 1'b1; memresp_data = 32'hDEAD;
        settle();
        chk("t2_imemresp_val", 32'(imemresp_val), 32'd1);
        chk("t2_dmemresp_val", 32'(dmemresp_val), 32'd0);
        chk("t2_imemresp_data", imemresp_data, 32'hDEAD);
        chk("t2_memresp_rdy", 32'(memresp_rdy), 32'd1);
        tick();
        memresp_val = 1'b0;
        chk("t2_drained", 32'(outstanding), 32'd0);

        // Both valid every cycle: prio starts at dmem, so grants go D,I,D,I until full.
        imemreq_val = 1'b1; imemreq_addr = 32'h300;
        dmemreq_val = 1'b1; dmemreq_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("t3_dgrant%0d", i), 32'(dmemreq_rdy), 32'((i % 2) == 0));
            chk($sformatf("t3_igrant%0d", i), 32'(imemreq_rdy), 32'((i % 2) == 1));
            chk($sformatf("t3_addr%0d", i), memreq_addr,
                ((i % 2) == 0) ? 32'h200 : 32'h300);
            tick();
            chk($sformatf("t3_occ%0d", i), 32'(outstanding), 32'(i + 1));
        end
        settle();
        chk("t3_full_memreq_val", 32'(memreq_val), 32'd0);
        chk("t3_full_imemreq_rdy", 32'(imemreq_rdy), 32'd0);
        chk("t3_full_dmemreq_rdy", 32'(dmemreq_rdy), 32'd0);

        // Full plus a response pop in the same cycle: no issue this cycle, one next cycle.
        memresp_val = 1'b1; memresp_data = 32'h1234;
        settle();
        chk("t4_memreq_val", 32'(memreq_val), 32'd0);
        chk("t4_dmemreq_rdy", 32'(dmemreq_rdy), 32'd0);
        chk("t4_head_dmem", 32'(dmemresp_val), 32'd1);
        chk("t4_memresp_rdy", 32'(memresp_rdy), 32'd1);
        tick();
        chk("t4_occ_pop", 32'(outstanding), 32'd3);
        memresp_val = 1'b0;
        settle();
        chk("t4_regrant_val", 32'(memreq_val), 32'd1);
        chk("t4_regrant_dmem", 32'(dmemreq_rdy), 32'd1);
        tick();
        chk("t4_occ_refill", 32'(outstanding), 32'd4);

        // Drain: queue now holds I,D,I,D from head.
        imemreq_val = 1'b0; dmemreq_val = 1'b0; memresp_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("t4_drain_i%0d", i), 32'(imemresp_val), 32'((i % 2) == 0));
            chk($sformatf("t4_drain_d%0d", i), 32'(dmemresp_val), 32'((i % 2) == 1));
            tick();
        end
        memresp_val = 1'b0;
        chk("t4_drained", 32'(outstanding), 32'd0);

        // I(0x0), D-write(0x40,0x55), I(0x4); then responses with dmem back-pressure.
        imemreq_val = 1'b1; imemreq_addr = 32'h0;
        settle();
        chk("t5_i0_rdy", 32'(imemreq_rdy), 32'd1);
        tick();
        imemreq_val = 1'b0;
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h40; dmemreq_wdata = 32'h55;
        settle();
        chk("t5_w_rdy", 32'(dmemreq_rdy), 32'd1);
        chk("t5_w_type", 32'(memreq_type), 32'd1);
        chk("t5_w_addr", memreq_addr, 32'h40);
        chk("t5_w_wdata", memreq_wdata, 32'h55);
        tick();
        dmemreq_val = 1'b0; dmemreq_type = 1'b0;
        imemreq_val = 1'b1; imemreq_addr = 32'h4;
        settle();
        chk("t5_i4_addr", memreq_addr, 32'h4);
        chk("t5_i4_wdata", memreq_wdata, 32'h0);
        tick();
        imemreq_val = 1'b0;
        chk("t5_occ3", 32'(outstanding), 32'd3);

        memresp_val = 1'b1; memresp_data = 32'hA0;
        settle();
        chk("t5_r0_imem", 32'(imemresp_val), 32'd1);
        chk("t5_r0_dmem", 32'(dmemresp_val), 32'd0);
        tick();
        dmemresp_rdy = 1'b0; memresp_data = 32'hB1;
        settle();
        chk("t5_stall_dval", 32'(dmemresp_val), 32'd1);
        chk("t5_stall_ival", 32'(imemresp_val), 32'd0);
        chk("t5_stall_rdy", 32'(memresp_rdy), 32'd0);
        tick();
        chk("t5_stall_occ", 32'(outstanding), 32'd2);
        dmemresp_rdy = 1'b1;
        settle();
        chk("t5_release_rdy", 32'(memresp_rdy), 32'd1);
        chk("t5_release_data", dmemresp_data, 32'hB1);
        tick();
        chk("t5_release_occ", 32'(outstanding), 32'd1);
        memresp_data = 32'hC2;
        settle();
        chk("t5_r2_imem", 32'(imemresp_val), 32'd1);
        tick();
        memresp_val = 1'b0;
        chk("t5_drained", 32'(outstanding), 32'd0);

        // Spurious response with the queue empty.
        memresp_val = 1'b1;
        settle();
        chk("t6_memresp_rdy", 32'(memresp_rdy), 32'd0);
        chk("t6_imemresp_val", 32'(imemresp_val), 32'd0);
        chk("t6_dmemresp_val", 32'(dmemresp_val), 32'd0);
        chk("t6_err_before", 32'(err), 32'd0);
        tick();
        memresp_val = 1'b0;
        chk("t6_err_set", 32'(err), 32'd1);
        tick();
        tick();
        chk("t6_err_sticky", 32'(err), 32'd1);
        chk("t6_occ", 32'(outstanding), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_err_async_clr", 32'(err), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
